// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared types and helpers for the frame streamer.
// Holds the streamer FSM state encoding and the address-width helper
// used to size raster address, column and row counters.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_DONE   = 2'd3
  } fs_state_e;

  // Bits needed to index 'depth' entries; never less than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_mem.sv
// frame_mem: frame buffer with one synchronous write port and one
// combinational read port. Contents are not reset.
module frame_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store one pixel per enabled cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: streams one stored frame in raster order on a
// valid/ready interface, with optional idle gaps between lines.
//
// Handshake: a pixel transfers on any cycle where valid_out && ready_in.
// While valid_out is high and ready_in is low, pixel_out/sof/eol hold.
// valid_out never drops without a transfer.
//
// Optional build feature (macro FRAME_STREAMER_PATTERN_EN): adds input
// pattern_en, sampled with start; when set, the frame carries the test
// pattern (x+y) instead of memory data.
//
// All outputs come straight from registers. The frame memory is read
// combinationally at the next raster address so the registered pixel is
// ready the cycle after the position advances.
module frame_streamer
  import frame_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int HBLANK       = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_en,
  input  logic [addr_w(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0]     wr_addr,
  input  logic [PIXEL_WIDTH-1:0]                          wr_data,
  input  logic                                            start,
  input  logic                                            ready_in,
`ifdef FRAME_STREAMER_PATTERN_EN
  input  logic                                            pattern_en,
`endif
  output logic [PIXEL_WIDTH-1:0]                          pixel_out,
  output logic                                            valid_out,
  output logic                                            sof,
  output logic                                            eol,
  output logic                                            busy,
  output logic                                            done
);

  localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW    = addr_w(DEPTH);
  localparam int XW    = addr_w(IMAGE_WIDTH);
  localparam int YW    = addr_w(IMAGE_HEIGHT);
  localparam int BW    = addr_w(HBLANK + 1);

  fs_state_e              state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [BW-1:0]          blank_q, blank_d;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic                   valid_q, valid_d;
  logic                   sof_q, sof_d;
  logic                   eol_q, eol_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [PIXEL_WIDTH-1:0] mem_rdata;
  logic [PIXEL_WIDTH-1:0] src_pix;
`ifdef FRAME_STREAMER_PATTERN_EN
  logic                   pat_q, pat_d;
`endif

  // Memory is writable only between frames, so a stalled pixel never
  // changes underneath the downstream consumer.
  frame_mem #(
    .DATA_W (PIXEL_WIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en && !busy_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (addr_d),
    .rdata_o (mem_rdata)
  );

  // Next-state logic: walks the raster, inserts line blanking, and
  // derives the registered output values from the next position.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    blank_d = blank_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    src_pix = mem_rdata;
`ifdef FRAME_STREAMER_PATTERN_EN
    pat_d   = pat_q;
`endif

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          blank_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef FRAME_STREAMER_PATTERN_EN
          pat_d   = pattern_en;
`endif
        end
      end
      ST_ACTIVE: begin
        if (ready_in) begin
          if (x_q != XW'(IMAGE_WIDTH - 1)) begin
            x_d    = x_q + XW'(1);
            addr_d = addr_q + AW'(1);
          end else if (y_q != YW'(IMAGE_HEIGHT - 1)) begin
            x_d    = '0;
            y_d    = y_q + YW'(1);
            addr_d = addr_q + AW'(1);
            if (HBLANK != 0) begin
              state_d = ST_HBLANK;
              valid_d = 1'b0;
              blank_d = '0;
            end
          end else begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (int'(blank_q) == HBLANK - 1) begin
          state_d = ST_ACTIVE;
          valid_d = 1'b1;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

`ifdef FRAME_STREAMER_PATTERN_EN
    if (pat_d) begin
      src_pix = PIXEL_WIDTH'(x_d) + PIXEL_WIDTH'(y_d);
    end
`endif

    if (valid_d) begin
      pix_d = src_pix;
      sof_d = (x_d == '0) && (y_d == '0);
      eol_d = (x_d == XW'(IMAGE_WIDTH - 1));
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      blank_q <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_STREAMER_PATTERN_EN
      pat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      blank_q <= blank_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FRAME_STREAMER_PATTERN_EN
      pat_q   <= pat_d;
`endif
    end
  end

  assign pixel_out = pix_q;
  assign valid_out = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
